// File: rtl/la_gcd_pkg.sv
// Shared types and LA bit-map helpers for the LA GCD responder.
package la_gcd_pkg;

  localparam int LA_W  = 128;
  localparam int CNT_W = 16;
  localparam int K_W   = 6;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    STRIP,
    ODDA,
    LOOP,
    FINISH,
    DONE
  } gcd_state_t;

  function automatic int req_pos(input int w);
    return 2 * w;
  endfunction

  function automatic int ack_pos(input int w);
    return w;
  endfunction

  function automatic int busy_pos(input int w);
    return w + 1;
  endfunction

  function automatic int cnt_lsb(input int w);
    return w + 2;
  endfunction

  // Worst-case cycles from accept to ack for a nonzero operand pair.
  function automatic int cycle_bound(input int w);
    return 5 * w + 8;
  endfunction

endpackage

// File: rtl/gcd_stein_core.sv
// Binary (Stein) GCD engine: latches operands on start, holds the result in DONE
// until the requester releases.
module gcd_stein_core
  import la_gcd_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         release_req,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
);

  gcd_state_t     state;
  gcd_state_t     state_next;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [K_W-1:0] k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (a == '0 || b == '0) state_next = DONE;
        else                    state_next = STRIP;
      end
      STRIP: begin
        busy = 1'b1;
        if (a[0] || b[0]) state_next = ODDA;
      end
      ODDA: begin
        busy = 1'b1;
        if (a[0]) state_next = LOOP;
      end
      LOOP: begin
        busy = 1'b1;
        // Two odd operands only subtract to zero when they are equal.
        if (b[0] && (a == b)) state_next = FINISH;
      end
      FINISH: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (release_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a      <= '0;
      b      <= '0;
      k      <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a <= a_in;
            b <= b_in;
          end
        end
        CHECK: begin
          if (a == '0)      result <= b;
          else if (b == '0) result <= a;
          else              k <= '0;
        end
        STRIP: begin
          if (!a[0] && !b[0]) begin
            a <= a >> 1;
            b <= b >> 1;
            k <= k + 1'b1;
          end
        end
        ODDA: begin
          if (!a[0]) a <= a >> 1;
        end
        LOOP: begin
          if (!b[0]) begin
            b <= b >> 1;
          end else if (a > b) begin
            a <= b;
            b <= a - b;
          end else begin
            b <= b - a;
          end
        end
        FINISH: begin
          result <= a << k;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/la_gcd_responder.sv
// LA-side wrapper: unpacks operands, qualifies the request, runs the four-phase
// handshake around the GCD core and reports a saturating busy-cycle count.
module la_gcd_responder
  import la_gcd_pkg::*;
#(
  parameter int W = 32
) (
  input  logic              wb_clk_i,
  input  logic              resetb,
  input  logic [LA_W-1:0]   la_data_in,
  input  logic [LA_W-1:0]   la_oenb,
  output logic [LA_W-1:0]   la_data_out
);

  localparam int REQ_BIT  = req_pos(W);
  localparam int ACK_BIT  = ack_pos(W);
  localparam int BUSY_BIT = busy_pos(W);
  localparam int CNT_LSB  = cnt_lsb(W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             eff_req;
  logic             accept;
  logic             busy;
  logic             ack;
  logic [W-1:0]     result;
  logic [CNT_W-1:0] count;
  logic             unused_ok;

  assign eff_req = la_data_in[REQ_BIT] & ~la_oenb[REQ_BIT];
  // A new request is only taken once the previous ack has fallen.
  assign accept  = eff_req & ~busy & ~ack;
  assign unused_ok = ^{la_oenb, la_data_in};

  gcd_stein_core #(
    .W(W)
  ) u_core (
    .clk         (wb_clk_i),
    .rst_n       (resetb),
    .start       (accept),
    .release_req (~eff_req),
    .a_in        (la_data_in[W-1:0]),
    .b_in        (la_data_in[2*W-1:W]),
    .busy        (busy),
    .done        (ack),
    .result      (result)
  );

  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      count <= '0;
    end else if (accept) begin
      count <= '0;
    end else if (busy && count != CNT_MAX) begin
      count <= count + 1'b1;
    end
  end

  always_comb begin
    la_data_out                       = '0;
    la_data_out[W-1:0]                = result;
    la_data_out[ACK_BIT]              = ack;
    la_data_out[BUSY_BIT]             = busy;
    la_data_out[CNT_LSB +: CNT_W]     = count;
  end

endmodule

// File: tb/tb_la_gcd_responder.sv
// Self-checking bench for la_gcd_responder against a Euclid-based GCD model.
module tb_la_gcd_responder;
  import la_gcd_pkg::*;

  localparam int W     = 32;
  localparam int REQ   = req_pos(W);
  localparam int ACKB  = ack_pos(W);
  localparam int BUSYB = busy_pos(W);
  localparam int CLSB  = cnt_lsb(W);
  localparam int BOUND = cycle_bound(W);

  logic         wb_clk_i = 1'b0;
  logic         resetb   = 1'b0;
  logic [127:0] la_data_in;
  logic [127:0] la_oenb;
  logic [127:0] la_data_out;

  logic         ack_o;
  logic         busy_o;
  logic [W-1:0] res_o;
  logic [15:0]  cnt_o;

  int checks = 0;
  int errors = 0;

  assign ack_o  = la_data_out[ACKB];
  assign busy_o = la_data_out[BUSYB];
  assign res_o  = la_data_out[W-1:0];
  assign cnt_o  = la_data_out[CLSB +: 16];

  always #5 wb_clk_i = ~wb_clk_i;

  la_gcd_responder #(
    .W(W)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .resetb      (resetb),
    .la_data_in  (la_data_in),
    .la_oenb     (la_oenb),
    .la_data_out (la_data_out)
  );

  function automatic logic [W-1:0] refGcd(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] p, q, t;
    p = x;
    q = y;
    while (q != '0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic req, input logic oen);
    la_data_in            = '0;
    la_data_in[W-1:0]     = a;
    la_data_in[2*W-1:W]   = b;
    la_data_in[REQ]       = req;
    la_oenb               = '1;
    la_oenb[REQ]          = oen;
  endtask

  task automatic waitAck(input string tag, output int lat, output int busy_cnt);
    logic overlap;
    lat      = 0;
    busy_cnt = 0;
    overlap  = 1'b0;
    for (int i = 1; i <= BOUND + 8; i++) begin
      step();
      if (busy_o) busy_cnt++;
      if (busy_o && ack_o) overlap = 1'b1;
      if (ack_o) begin
        lat = i;
        break;
      end
    end
    checkOutput({tag, "_ack_seen"}, 128'(ack_o), 128'(1));
    checkOutput({tag, "_busy_ack_overlap"}, 128'(overlap), 128'(0));
    if (lat != 0) checkOutput({tag, "_within_bound"}, 128'(lat <= BOUND), 128'(1));
  endtask

  task automatic runGcd(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat);
    int lat, bc;
    logic [W-1:0] expv;
    expv = refGcd(a, b);
    applyStimulus(a, b, 1'b1, 1'b0);
    waitAck(tag, lat, bc);
    checkOutput({tag, "_result"}, 128'(res_o), 128'(expv));
    checkOutput({tag, "_count"}, 128'(cnt_o), 128'(bc));
    if (exp_lat > 0) begin
      checkOutput({tag, "_latency"}, 128'(lat), 128'(exp_lat));
      checkOutput({tag, "_count_one"}, 128'(cnt_o), 128'(1));
    end
    applyStimulus(a, b, 1'b0, 1'b0);
    step();
    checkOutput({tag, "_ack_drop"}, 128'(ack_o), 128'(0));
    checkOutput({tag, "_result_hold"}, 128'(res_o), 128'(expv));
    checkOutput({tag, "_count_hold"}, 128'(cnt_o), 128'(bc));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    logic [W-1:0] x, y, a, b;
    int lat, bc, mode;

    applyStimulus('0, '0, 1'b0, 1'b1);
    #12;
    checkOutput("reset_out", la_data_out, '0);
    step();
    resetb = 1'b1;
    step();
    checkOutput("idle_out", la_data_out, '0);

    runGcd("plan", 32'd10312050, 32'd29460792, 0);

    ta = '{32'd1993627629, 32'd2097015289, 32'd1924134885, 32'd992211318};
    tb = '{32'd1177417612, 32'd3812041926, 32'd3151131255, 32'd512609597};
    for (int i = 0; i < 4; i++) runGcd($sformatf("b2b%0d", i), ta[i], tb[i], 0);

    runGcd("zero_a", 32'd0, 32'd42, 2);
    runGcd("zero_b", 32'd42, 32'd0, 2);
    runGcd("zero_ab", 32'd0, 32'd0, 2);

    // Masked request must be ignored until the enable bit clears.
    applyStimulus(32'd84, 32'd36, 1'b1, 1'b1);
    repeat (3) step();
    checkOutput("oenb_no_accept", 128'(busy_o), 128'(0));
    la_oenb[REQ] = 1'b0;
    step();
    checkOutput("oenb_accept", 128'(busy_o), 128'(1));
    waitAck("oenb", lat, bc);
    checkOutput("oenb_result", 128'(res_o), 128'(refGcd(32'd84, 32'd36)));
    applyStimulus('0, '0, 1'b0, 1'b0);
    step();

    // One-cycle request pulse with operands scrambled during the run.
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    step();
    checkOutput("pulse_accept", 128'(busy_o), 128'(1));
    applyStimulus($urandom, $urandom, 1'b0, 1'b0);
    waitAck("pulse", lat, bc);
    checkOutput("pulse_result", 128'(res_o), 128'(refGcd(32'h8000_0000, 32'h8000_0000)));
    step();
    checkOutput("pulse_ack_one_cycle", 128'(ack_o), 128'(0));

    // Asynchronous reset in the middle of the subtract loop.
    applyStimulus(32'h8000_0000, 32'd3, 1'b1, 1'b0);
    repeat (36) step();
    checkOutput("midloop_busy", 128'(busy_o), 128'(1));
    #2;
    resetb = 1'b0;
    #1;
    checkOutput("midloop_reset_out", la_data_out, '0);
    applyStimulus('0, '0, 1'b0, 1'b0);
    step();
    resetb = 1'b1;
    step();
    checkOutput("post_reset_out", la_data_out, '0);
    runGcd("reset_rerun", 32'h8000_0000, 32'd3, 0);

    for (int i = 0; i < 16; i++) begin
      x    = $urandom;
      y    = $urandom;
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin
          a = (x >> 12) * W'($urandom_range(1, 4095));
          b = (y >> 12) * W'($urandom_range(1, 4095));
        end
        1: begin
          a = (x >> 8) << $urandom_range(0, 8);
          b = (y >> 8) << $urandom_range(0, 8);
        end
        2: begin
          a = x;
          b = y;
        end
        default: begin
          a = x;
          b = y;
          if (x[0]) a = '0;
          else      b = '0;
        end
      endcase
      runGcd($sformatf("rand%0d", i), a, b, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
